bcd_conversion_arbiter: RTL and testbench
=========================================

# bcd_conversion_arbiter

Shares one binary_to_bcd_converter between several requesters, for example the per-class score readouts of the recognition network feeding the display path. It sequences the converter's start/end-of-conversion handshake and serves requesters in round-robin order. It latches each requester's 8-bit operand at grant time and returns the 12-bit BCD result with a one-cycle acknowledge to the granted requester only.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 31, WAIT-state cycle limit; used only when BCD_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- req  in  NUM_REQ  level request per channel; held until that channel's ack
- req_data  in  8*NUM_REQ  packed operands; channel i at [8i+7:8i]
- ack  out  NUM_REQ  one-hot, one-cycle pulse; result_bcd is valid in that cycle
- result_bcd  out  12  registered result of the last completed service
- result_err  out  1  high with ack when the service timed out
- busy  out  1  high in any state other than IDLE
- conv_start  out  1  one-cycle start pulse to the converter
- conv_binary  out  8  registered operand to the converter
- conv_eoc  in  1  converter end_of_conversion pulse
- conv_bcd  in  12  converter bcd_data

## Operation
- State register takes four states: IDLE, LAUNCH, WAIT, DONE.
- Round-robin pointer last_grant resets to NUM_REQ-1, so channel 0 has first priority.
- IDLE:
  - If any req bit is high, grant the first high channel searching upward from last_grant+1 with wrap-around.
  - Register the grant index and latch req_data[grant] into conv_binary.
  - Go to LAUNCH.
- LAUNCH: conv_start=1 for this cycle only; go to WAIT.
- WAIT:
  - On conv_eoc=1, capture conv_bcd into result_bcd, clear result_err, and go to DONE.
  - conv_eoc seen in any other state is ignored.
- DONE:
  - ack[grant]=1 for this cycle.
  - last_grant is updated to grant; go to IDLE.
- Operand handling:
  - The operand is sampled only at grant. Later changes to req_data or req do not affect the service in flight.
  - A granted channel that drops req still completes and receives ack.
  - A channel that drops req before it is granted is not served.
- A req still high in the cycle after ack is treated as a new request and competes under round-robin.
- result_bcd holds its value between services.
- Reset, including mid-operation:
  - Next state is IDLE, last_grant=NUM_REQ-1.
  - ack, conv_start, busy and result_err go to 0; result_bcd and conv_binary go to 0.
  - A converter conversion in progress is abandoned. Its late conv_eoc arrives outside WAIT and is ignored.

## Timing
- Request accepted at edge k (state IDLE) → conv_start high during cycle k+1.
- The converter asserts conv_eoc about 9 cycles after sampling start (8 shift cycles plus the result cycle).
- conv_eoc sampled at edge m → ack and result_bcd valid during cycle m+1.
- Request-to-ack latency = 3 cycles + converter latency.
- Back-to-back: one IDLE cycle separates DONE from the next grant.
- busy rises the cycle after grant and falls in the cycle after DONE.

## Configuration
- BCD_ARB_TIMEOUT_EN defined:
  - A 5-bit counter is cleared on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without conv_eoc: result_bcd=0, result_err=1, go to DONE. ack is pulsed normally.
  - conv_eoc arriving in the same cycle as the timeout wins; result_err=0.
- Not defined: no counter is built, WAIT waits indefinitely, and result_err is tied to 0.

## Test plan
- Single request: req[0]=1, data 8'd255 → exactly one conv_start pulse with conv_binary=255; ack=4'b0001 one cycle after conv_eoc; result_bcd=12'h255.
- Simultaneous requests: all four raised at once with 10, 20, 30, 40, each dropped after its ack → served in order 0,1,2,3 with results 12'h010, 12'h020, 12'h030, 12'h040.
- Fairness: req[1] and req[3] held high continuously → ack alternates 4'b0010, 4'b1000, 4'b0010, …; channels 0 and 2 are never acked.
- Operand stability: req[2] granted with 8'd99; req_data changed to 8'd7 during WAIT → result_bcd=12'h099.
- Reset during WAIT → cycle after reset, all outputs are 0 and state is IDLE; the converter's late conv_eoc produces no ack; the next request from channels 0 and 1 together serves channel 0 first.
- Timeout, macro defined: converter stub never asserts eoc → ack at WAIT entry + 31 cycles, with result_err=1 and result_bcd=0. Macro undefined: busy stays high and no ack is issued.

Source files
------------

// File: rtl/bcd_conversion_arbiter_if.sv
// bcd_conversion_arbiter_if: requester and converter signals of the shared BCD converter arbiter
interface bcd_conversion_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] ack;
  logic [11:0] result_bcd;
  logic result_err;
  logic busy;
  logic conv_start;
  logic [7:0] conv_binary;
  logic conv_eoc;
  logic [11:0] conv_bcd;
  modport master (
    output req, req_data, conv_eoc, conv_bcd,
    input ack, result_bcd, result_err, busy, conv_start, conv_binary
  );
  modport slave (
    input req, req_data, conv_eoc, conv_bcd,
    output ack, result_bcd, result_err, busy, conv_start, conv_binary
  );
endinterface

// File: rtl/bcd_conversion_arbiter.sv
// bcd_conversion_arbiter: round-robin sharing of one binary_to_bcd_converter; BCD_ARB_TIMEOUT_EN adds a WAIT timeout
module bcd_conversion_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 31
) (
  input logic clk,
  input logic reset,
  bcd_conversion_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state;
  logic [IW-1:0] last_grant, grant, pick, idx;
  logic found;
  logic [7:0] operand;
`ifdef BCD_ARB_TIMEOUT_EN
  logic [4:0] wait_cnt;
`endif
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_param_check
    $error("bcd_conversion_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..31");
  end
  // first requesting channel above last_grant with wrap-around, and its operand
  always_comb begin
    found = 1'b0;
    pick = last_grant;
    idx = last_grant;
    operand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) operand = (pick == IW'(i)) ? bus.req_data[8*i +: 8] : operand;
  end
  // handshake sequencer with registered outputs; start and ack are single-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant <= '0;
      bus.ack <= '0;
      bus.conv_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.result_err <= 1'b0;
      bus.result_bcd <= '0;
      bus.conv_binary <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      bus.ack <= '0;
      bus.conv_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          bus.conv_binary <= operand;
          bus.conv_start <= 1'b1;
          bus.busy <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (bus.conv_eoc) begin
          bus.result_bcd <= bus.conv_bcd;
          bus.result_err <= 1'b0;
          bus.ack <= NUM_REQ'(1) << grant;
          state <= DONE;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (wait_cnt == 5'(TIMEOUT_CYCLES - 1)) begin
          bus.result_bcd <= '0;
          bus.result_err <= 1'b1;
          bus.ack <= NUM_REQ'(1) << grant;
          state <= DONE;
        end else wait_cnt <= wait_cnt + 5'd1;
`endif
        DONE: begin
          last_grant <= grant;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// tb_bcd_conversion_arbiter: directed vectors plus corner sequences against a converter stub
module tb_bcd_conversion_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bcd_conversion_arbiter_if #(.NUM_REQ(4)) bus();
  bcd_conversion_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(31)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  logic eoc_en = 1'b1;
  int conv_cnt = 0;
  logic [7:0] conv_op = '0;
  int starts = 0;
  function automatic logic [11:0] to_bcd(input logic [7:0] x);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction
  // converter stub: eoc nine cycles after sampling start, result from the latched operand
  always @(posedge clk) begin
    if (bus.conv_start) begin
      conv_cnt <= 9;
      conv_op <= bus.conv_binary;
      starts <= starts + 1;
    end else if (conv_cnt > 0) conv_cnt <= conv_cnt - 1;
  end
  assign bus.conv_eoc = eoc_en && conv_cnt == 1;
  assign bus.conv_bcd = to_bcd(conv_op);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_ack(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack == 0 && cyc < limit);
  endtask
  task automatic wait_start(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.conv_start && n < limit);
    check("start_seen", 32'(bus.conv_start), 1);
  endtask
  task automatic check_cleared(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.result_err), 0);
    check({tag, "_bcd"}, 32'(bus.result_bcd), 0);
    check({tag, "_start"}, 32'(bus.conv_start), 0);
    check({tag, "_binary"}, 32'(bus.conv_binary), 0);
  endtask
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] ack;
    logic [11:0] bcd;
    int lat;
  } vec_t;
  vec_t v[9];
  initial begin
    int cyc, s0, acks, eocs, low;
    v[0] = '{1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, 4'b0001, 12'h255, 11};
    v[1] = '{1'b1, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0001, 12'h010, 11};
    v[2] = '{1'b0, 4'b1110, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0010, 12'h020, 12};
    v[3] = '{1'b0, 4'b1100, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0100, 12'h030, 12};
    v[4] = '{1'b0, 4'b1000, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b1000, 12'h040, 12};
    v[5] = '{1'b0, 4'b1010, {8'd64, 8'd22, 8'd128, 8'd11}, 4'b0010, 12'h128, 12};
    v[6] = '{1'b0, 4'b1010, {8'd64, 8'd22, 8'd128, 8'd11}, 4'b1000, 12'h064, 12};
    v[7] = '{1'b0, 4'b1010, {8'd64, 8'd22, 8'd0, 8'd11}, 4'b0010, 12'h000, 12};
    v[8] = '{1'b0, 4'b1010, {8'd9, 8'd22, 8'd0, 8'd11}, 4'b1000, 12'h009, 12};
    bus.req = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_cleared("reset");
    for (int i = 0; i < 9; i++) begin
      if (v[i].rst) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      bus.req = v[i].req;
      bus.req_data = v[i].data;
      s0 = starts;
      wait_ack(60, cyc);
      check($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(v[i].ack));
      check($sformatf("v%0d_bcd", i), 32'(bus.result_bcd), 32'(v[i].bcd));
      check($sformatf("v%0d_err", i), 32'(bus.result_err), 0);
      check($sformatf("v%0d_starts", i), 32'(starts - s0), 1);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(v[i].lat));
    end
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0100;
    bus.req_data = {8'd1, 8'd99, 8'd2, 8'd3};
    wait_start(5);
    check("stab_binary", 32'(bus.conv_binary), 99);
    check("stab_busy", 32'(bus.busy), 1);
    repeat (2) @(negedge clk);
    bus.req_data[23:16] = 8'd7;
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    bus.req = 4'b0000;
    wait_ack(60, cyc);
    check("stab_ack", 32'(bus.ack), 32'(4'b0100));
    check("stab_bcd", 32'(bus.result_bcd), 32'(12'h099));
    acks = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.ack != 0 || bus.busy) acks++;
    end
    check("dropped_req_unserved", 32'(acks), 0);
    bus.req = 4'b0001;
    bus.req_data = {8'd0, 8'd0, 8'd77, 8'd5};
    wait_ack(60, cyc);
    check("pre_ack", 32'(bus.ack), 32'(4'b0001));
    check("pre_bcd", 32'(bus.result_bcd), 32'(12'h005));
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0010;
    wait_start(5);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("midreset");
    acks = 0;
    eocs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack != 0) acks++;
      if (bus.conv_eoc) eocs++;
    end
    check("late_eoc_seen", 32'(eocs), 1);
    check("late_eoc_no_ack", 32'(acks), 0);
    bus.req = 4'b0011;
    bus.req_data = {8'd0, 8'd0, 8'd2, 8'd1};
    wait_ack(60, cyc);
    check("post_reset_first", 32'(bus.ack), 32'(4'b0001));
    check("post_reset_first_bcd", 32'(bus.result_bcd), 32'(12'h001));
    bus.req = 4'b0010;
    wait_ack(60, cyc);
    check("post_reset_second", 32'(bus.ack), 32'(4'b0010));
    check("post_reset_second_bcd", 32'(bus.result_bcd), 32'(12'h002));
    bus.req = '0;
    @(negedge clk);
    eoc_en = 1'b0;
    bus.req = 4'b0001;
    bus.req_data = {8'd0, 8'd0, 8'd0, 8'd200};
`ifdef BCD_ARB_TIMEOUT_EN
    wait_ack(60, cyc);
    check("timeout_ack", 32'(bus.ack), 32'(4'b0001));
    check("timeout_err", 32'(bus.result_err), 1);
    check("timeout_bcd", 32'(bus.result_bcd), 0);
    check("timeout_latency", 32'(cyc), 33);
    bus.req = '0;
`else
    acks = 0;
    low = 0;
    @(negedge clk);
    bus.req = '0;
    repeat (60) begin
      @(negedge clk);
      if (bus.ack != 0) acks++;
      if (!bus.busy) low++;
    end
    check("no_timeout_ack", 32'(acks), 0);
    check("no_timeout_busy_low", 32'(low), 0);
    check("no_timeout_err", 32'(bus.result_err), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    eoc_en = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
